// File: rtl/traffic_light_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl_if
// Description : Bundles the car-detect input and the light-head outputs of
//               the highway/farm-road traffic light controller.
//               master : environment side (drives C_sync, observes lights)
//               slave  : controller side  (samples C_sync, drives lights)
//   C_sync  1 bit  synchronized farm-road car present (1 = car waiting)
//   HL      2 bit  highway light: 00 green, 01 yellow, 10 red
//   FL      2 bit  farm light, same encoding as HL
//   state_o 2 bit  current controller state (HG=0, HY=1, FG=2, FY=3)
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_ctrl_if;
    logic       C_sync;
    logic [1:0] HL;
    logic [1:0] FL;
    logic [1:0] state_o;

    modport master (
        output C_sync,
        input  HL,
        input  FL,
        input  state_o
    );

    modport slave (
        input  C_sync,
        output HL,
        output FL,
        output state_o
    );
endinterface
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Highway/farm-road traffic light controller. Moore FSM with
//               four states (HG, HY, FG, FY) and an 8-bit saturating dwell
//               timer. The highway has priority; the farm road is served
//               only while a car is waiting.
// Ports       :
//   clk      in   system clock, rising-edge active
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of traffic_light_ctrl_if
//            (C_sync in, HL/FL/state_o out)
// Parameters  :
//   LONG_CYCLES  minimum green dwell in cycles (2..255)
//   SHORT_CYCLES exact yellow dwell in cycles (1..255, < LONG_CYCLES)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int LONG_CYCLES  = 8,
    parameter int SHORT_CYCLES = 3
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    traffic_light_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        HG = 2'd0,
        HY = 2'd1,
        FG = 2'd2,
        FY = 2'd3
    } state_t;

    localparam logic [1:0] c_GREEN  = 2'b00;
    localparam logic [1:0] c_YELLOW = 2'b01;
    localparam logic [1:0] c_RED    = 2'b10;

    // The timer reads 0 in the first cycle of a state, so a dwell of N
    // cycles is complete once the timer has reached N-1.
    localparam logic [7:0] c_TL_LIMIT = 8'(LONG_CYCLES - 1);
    localparam logic [7:0] c_TS_LIMIT = 8'(SHORT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] hl_q, fl_q;
    logic       w_tl, w_ts;

    assign w_tl = (timer_q >= c_TL_LIMIT);
    assign w_ts = (timer_q >= c_TS_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG:      if (bus.C_sync && w_tl)  state_d = HY;
            HY:      if (w_ts)                state_d = FG;
            FG:      if (!bus.C_sync || w_tl) state_d = FY;
            FY:      if (w_ts)                state_d = HG;
            default:                          state_d = HG;
        endcase

        // Restart the dwell count on every state change; otherwise count up
        // and hold at 255 so a long idle HG never wraps back below TL.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != 8'hFF) begin
            timer_d = timer_q + 8'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Light outputs are registered from the next state so they change on the
    // same edge as the state register and carry no path from C_sync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HG;
            timer_q <= '0;
            hl_q    <= c_GREEN;
            fl_q    <= c_RED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            case (state_d)
                HG: begin
                    hl_q <= c_GREEN;
                    fl_q <= c_RED;
                end
                HY: begin
                    hl_q <= c_YELLOW;
                    fl_q <= c_RED;
                end
                FG: begin
                    hl_q <= c_RED;
                    fl_q <= c_GREEN;
                end
                FY: begin
                    hl_q <= c_RED;
                    fl_q <= c_YELLOW;
                end
                default: begin
                    hl_q <= c_GREEN;
                    fl_q <= c_RED;
                end
            endcase
        end
    end

    assign bus.HL      = hl_q;
    assign bus.FL      = fl_q;
    assign bus.state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Self-checking bench for traffic_light_ctrl (LONG=8, SHORT=3).
//               Each vector holds the C_sync value sampled by the next clock
//               edge and the state/light values expected after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] S_HG = 2'd0;
    localparam logic [1:0] S_HY = 2'd1;
    localparam logic [1:0] S_FG = 2'd2;
    localparam logic [1:0] S_FY = 2'd3;

    typedef struct {
        logic       c;
        logic [1:0] st;
        logic [1:0] hl;
        logic [1:0] fl;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    vec_t vecs[$];

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .LONG_CYCLES  (8),
        .SHORT_CYCLES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic [1:0] hl, input logic [1:0] fl);
        chk({tag, ".state"}, bus.state_o, st);
        chk({tag, ".HL"},    bus.HL,      hl);
        chk({tag, ".FL"},    bus.FL,      fl);
    endtask

    // Append n identical vectors.
    task automatic add(input logic c, input logic [1:0] st,
                       input logic [1:0] hl, input logic [1:0] fl, input int n);
        vec_t v;
        v.c = c; v.st = st; v.hl = hl; v.fl = fl;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Called at a negedge: drive input, let one rising edge pass, check at
    // the following negedge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            bus.C_sync = vecs[i].c;
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("%s[%0d]", tag, i), vecs[i].st, vecs[i].hl, vecs[i].fl);
        end
        vecs.delete();
    endtask

    // Assert reset at a negedge, check the reset state, release at the next
    // negedge so the following rising edge is the first functional one.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all({tag, ".rst"}, S_HG, G, R);
        @(negedge clk);
        reset_n = 1'b1;
        chk_all({tag, ".rel"}, S_HG, G, R);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        bus.C_sync = 1'b0;

        // 1. Idle road: highway stays green.
        do_reset("idle");
        add(1'b0, S_HG, G, R, 50);
        run_vecs("idle");

        // 2. Continuous demand: HG 8, HY 3, FG 8, FY 3, HG 8, then HY.
        do_reset("cont");
        add(1'b1, S_HG, G, R, 7);
        add(1'b1, S_HY, Y, R, 3);
        add(1'b1, S_FG, R, G, 8);
        add(1'b1, S_FY, R, Y, 3);
        add(1'b1, S_HG, G, R, 8);
        add(1'b1, S_HY, Y, R, 1);
        run_vecs("cont");

        // 3. Late arrival: HY on the first edge sampling C_sync=1.
        do_reset("late");
        add(1'b0, S_HG, G, R, 20);
        add(1'b1, S_HY, Y, R, 1);
        add(1'b0, S_HY, Y, R, 2);
        add(1'b0, S_FG, R, G, 1);
        add(1'b0, S_FY, R, Y, 1);
        run_vecs("late");

        // 4. Car leaves in the 2nd FG cycle: FY next edge, 3 cycles, then HG.
        do_reset("leave");
        add(1'b1, S_HG, G, R, 7);
        add(1'b1, S_HY, Y, R, 3);
        add(1'b1, S_FG, R, G, 2);
        add(1'b0, S_FY, R, Y, 3);
        add(1'b0, S_HG, G, R, 3);
        run_vecs("leave");

        // 5. Yellow ignores C_sync toggling.
        do_reset("yel");
        add(1'b1, S_HG, G, R, 7);
        add(1'b1, S_HY, Y, R, 1);
        add(1'b0, S_HY, Y, R, 1);
        add(1'b1, S_HY, Y, R, 1);
        add(1'b0, S_FG, R, G, 1);
        add(1'b0, S_FY, R, Y, 1);
        add(1'b1, S_FY, R, Y, 1);
        add(1'b0, S_FY, R, Y, 1);
        add(1'b1, S_HG, G, R, 1);
        run_vecs("yel");

        // 6. Async reset in the middle of FG, then full HG dwell again.
        do_reset("arst");
        add(1'b1, S_HG, G, R, 7);
        add(1'b1, S_HY, Y, R, 3);
        add(1'b1, S_FG, R, G, 2);
        run_vecs("arst_pre");
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("arst.async", S_HG, G, R);
        @(negedge clk);
        reset_n = 1'b1;
        add(1'b1, S_HG, G, R, 7);
        add(1'b1, S_HY, Y, R, 1);
        run_vecs("arst_post");

        // Timer saturation: after 258 idle edges a wrapping counter would
        // read 2; a saturating one still satisfies TL and goes to HY at once.
        do_reset("sat");
        for (int i = 0; i < 258; i++) begin
            bus.C_sync = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk_all("sat.idle", S_HG, G, R);
        add(1'b1, S_HY, Y, R, 1);
        run_vecs("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Highway/farm-road traffic light controller that consumes the synchronized farm-road car-detect signal C_sync.
- Sits directly downstream of the car-sensor synchronizer.
- Moore FSM with four states plus an internal dwell timer.
- Drives both light heads; the highway has priority and the farm road is served only on demand.

Parameters:
- LONG_CYCLES, 8: minimum green dwell in cycles. Legal range 2..255.
- SHORT_CYCLES, 3: exact yellow dwell in cycles. Legal range 1..255, and must be less than LONG_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- C_sync  input  1  synchronized farm-road car present, 1 = car waiting
- HL  output  2  highway light: 2'b00 green, 2'b01 yellow, 2'b10 red
- FL  output  2  farm light, same encoding as HL
- state_o  output  2  current state (debug): HG=0, HY=1, FG=2, FY=3

Behaviour:
- Reset:
  - reset_n low forces state=HG and timer=0 immediately, without waiting for a clock edge.
  - Outputs during and right after reset: HL=00, FL=10, state_o=0.
  - Reset asserted mid-cycle in any state has the same immediate effect.
- Outputs are pure decodes of the state register (Moore). They change only after a clk edge or on reset. No combinational path from C_sync to any output.
- Timer:
  - 8-bit up-counter. Cleared to 0 on the edge that changes state; otherwise increments each cycle.
  - Saturates at 255 and never wraps.
  - TL = (timer >= LONG_CYCLES-1).
  - TS = (timer >= SHORT_CYCLES-1).
  - The first cycle in a state has timer=0.
- State decodes:
  - HG: HL=green, FL=red.
  - HY: HL=yellow, FL=red.
  - FG: HL=red, FL=green.
  - FY: HL=red, FL=yellow.
- Transitions, evaluated at each rising edge:
  - HG -> HY when C_sync && TL. Otherwise stay. HG therefore lasts at least LONG_CYCLES cycles.
  - HY -> FG when TS. HY lasts exactly SHORT_CYCLES cycles; C_sync is ignored.
  - FG -> FY when !C_sync || TL. FG lasts 1..LONG_CYCLES cycles.
  - FY -> HG when TS. FY lasts exactly SHORT_CYCLES cycles; C_sync is ignored.
- Boundary cases:
  - C_sync rising after HG has already exceeded LONG_CYCLES: the timer is saturated or above threshold, so HG -> HY on the first edge that samples C_sync=1.
  - C_sync high and TL true on the same edge in HG: transition.
  - C_sync dropping on the same edge FG would reach TL: a single transition to FY, never a skip.
  - C_sync continuously high: the controller cycles HG(LONG) -> HY(SHORT) -> FG(LONG) -> FY(SHORT) indefinitely, and HG is still held its full LONG_CYCLES.
  - Illegal state encodings cannot occur (2-bit register, all 4 codes used). The default branch returns to HG.
- Latency: one clk edge from a sampled qualifying condition to the new light outputs.

Test Plan:
All scenarios use LONG_CYCLES=8 and SHORT_CYCLES=3.
1. Idle road: release reset_n, hold C_sync=0 for 50 cycles -> state_o=0, HL=00, FL=10 every cycle.
2. Continuous demand: C_sync=1 from reset release -> HG 8 cycles, HY 3, FG 8, FY 3, then HG 8 again. Check HL/FL at every cycle boundary.
3. Late arrival: C_sync=0 for 20 cycles, then 1 -> HY on the first edge that samples C_sync=1, HL=01, FL=10.
4. Car leaves early: in FG, drop C_sync at the 2nd FG cycle -> FY on the next edge, FY lasts exactly 3 cycles, then HG.
5. Yellow ignores input: toggle C_sync every cycle during HY and during FY -> each still lasts exactly 3 cycles.
6. Async reset: pull reset_n low mid-FG between clock edges -> HL=00, FL=10, state_o=0 with no clk edge. After release, HG holds at least 8 cycles with C_sync=1.
